pmod_cls_spi_responder: RTL and testbench
=========================================

# pmod_cls_spi_responder

SPI Mode 0 responder that emulates the PMOD CLS display end of the link: it receives bytes from the CLS SPI driver, decodes the ANSI escape subset (clear display, cursor position), and maintains a 2x16 character buffer. It sits in the verification and loopback harness in place of the physical PMOD CLS, so the display-writing path can be checked in hardware or simulation without the module.

## Interface
- FCLK, 20000000: frequency of i_ext_spi_clk_x in Hz. Must be at least 8x the SCK frequency.
- i_ext_spi_clk_x  in  1  system clock; every register samples on its rising edge.
- i_arst_n  in  1  asynchronous, active-low reset.
- i_sck, i_csn, i_copi  in  1 each  SPI pins, asynchronous to the clock. CSn is active-low.
- o_line1, o_line2  out  t_pmod_cls_ascii_line_16 (128)  display buffer. Column 0 is at bits [127:120].
- o_cursor_row  out  1  current row.
- o_cursor_col  out  4  current column.
- o_byte_valid  out  1  one-cycle pulse when a byte is received.
- o_byte_data  out  8  last received byte; holds its value between pulses.
- o_cmd_clear, o_cmd_cursor  out  1 each  one-cycle pulse when a command is executed.
- o_frame_err  out  1  one-cycle pulse when CSn rises with a partial byte or an unfinished escape sequence.
- o_seq_err  out  1  one-cycle pulse when an illegal byte appears inside an escape sequence.

## Operation
- Reset values:
  - Both lines are all 8'h20 (spaces).
  - Cursor is at 0,0.
  - All pulse outputs are 0 and o_byte_data is 0.
  - Decoder is in ST_TEXT and the bit counter is 0.
- Byte receiver:
  - While CSn is low, sample COPI on each synchronized SCK rising edge, MSB first.
  - On the 8th bit, pulse o_byte_valid and clear the bit counter.
  - A CSn rising edge clears the bit counter and discards any partial byte.
- Decoder FSM states: ST_TEXT, ST_ESC, ST_CSI, ST_PARAM.
- ST_TEXT:
  - ESC (8'h1B) moves to ST_ESC.
  - A printable byte (8'h20..8'h7E) is written at the cursor, then the column increments.
  - Any other byte is ignored.
- ST_ESC:
  - '[' moves to ST_CSI and sets p0 = 0, p1 = 0, idx = 0.
  - Any other byte pulses o_seq_err and returns to ST_TEXT.
- ST_CSI / ST_PARAM:
  - A digit updates p[idx] = p[idx]*10 + digit. Each parameter is 7 bits and saturates at 99.
  - ';' sets idx = 1. A second ';' is a sequence error.
  - Final 'j': if p0 == 0, fill both lines with 8'h20, set cursor to 0,0 and pulse o_cmd_clear. Otherwise the command is ignored. Return to ST_TEXT.
  - Final 'H': if p0 ≤ 1 and p1 ≤ 15, set cursor to p0,p1 and pulse o_cmd_cursor. Otherwise the command is ignored. Return to ST_TEXT.
  - Any other byte pulses o_seq_err and returns to ST_TEXT.
- Column at 15 after a text write: behaviour is set under Configuration.
- CSn rising edge:
  - Pulse o_frame_err if the bit counter is nonzero or the decoder is not in ST_TEXT.
  - Force the decoder to ST_TEXT.
  - Buffer and cursor are retained.
- Reset asserted mid-transfer: all state returns to reset values immediately.

## Timing
- SCK, CSn and COPI each pass through a 2-flop synchronizer. Edges are detected on the third flop.
- o_byte_valid asserts 3 clocks after the 8th SCK rising edge at the pins.
- Buffer, cursor and command pulses update on the clock after o_byte_valid.
- If a byte completion and a CSn rise are detected in the same cycle, the byte is decoded first and the decoder reset happens on the next cycle.
- Back-to-back bytes are accepted with no gap requirement beyond the FCLK ≥ 8x SCK ratio.

## Configuration
- PMOD_CLS_RESP_WRAP_EN defined: a write at column 15 moves the cursor to column 0 of the other row (row 1 wraps to row 0).
- PMOD_CLS_RESP_WRAP_EN undefined: the column saturates at 15, each further text byte overwrites column 15, and the row is unchanged.

## Structure
- pmod_stand_spi_solo_pkg gains:
  - t_cls_resp_state
  - ASCII_CLS_CHAR_NINE (8'h39)
  - ASCII_CLS_CHAR_SPACE (8'h20)
  - c_cls_resp_max_param (99)
- The package already provides ASCII_CLS_ESC, ASCII_CLS_BRACKET, ASCII_CLS_CHAR_ZERO, ASCII_CLS_CHAR_SEMICOLON, ASCII_CLS_DISP_CLR_CMD, ASCII_CLS_CURSOR_POS_CMD and t_pmod_cls_ascii_line_16; the block reuses these.
- Sub-module spi_mode0_byte_rx contains the synchronizers, edge detect and shift register. Its outputs are a byte strobe, the byte, CSn-rise, and a partial-byte flag.

## Test plan
- Send 1B 5B 30 6A in one CSn frame after the lines are filled with 'A' -> both lines 8'h20, cursor 0,0, one o_cmd_clear pulse.
- Send 1B 5B 31 3B 30 30 48 in one frame, then "HELLO WORLD 1234" in a second frame -> cursor reaches 1,0 and o_line2 = "HELLO WORLD 1234". Final column is 15 when the macro is undefined, 0,0 when it is defined.
- Raise CSn after 5 bits -> o_frame_err pulses, no o_byte_valid, buffer unchanged.
- Send 1B 5B 32 3B 30 48 -> row out of range, so cursor is unchanged and there is no o_cmd_cursor pulse. Then send 1B 41 -> o_seq_err pulses.
- Send 17 printable bytes from 0,0 with the macro undefined -> byte 17 overwrites column 15. With the macro defined -> byte 17 lands at row 1, column 0.
- Assert i_arst_n low mid-byte -> all outputs return to reset values on the same edge of i_arst_n.

Source files
------------

// File: rtl/pmod_stand_spi_solo_pkg.sv
// Shared ASCII codes, types and helpers for the PMOD CLS SPI link and its responder model.
package pmod_stand_spi_solo_pkg;

  localparam logic [7:0] ASCII_CLS_ESC            = 8'h1B;
  localparam logic [7:0] ASCII_CLS_BRACKET        = 8'h5B;
  localparam logic [7:0] ASCII_CLS_CHAR_ZERO      = 8'h30;
  localparam logic [7:0] ASCII_CLS_CHAR_NINE      = 8'h39;
  localparam logic [7:0] ASCII_CLS_CHAR_SEMICOLON = 8'h3B;
  localparam logic [7:0] ASCII_CLS_CHAR_SPACE     = 8'h20;
  localparam logic [7:0] ASCII_CLS_CHAR_TILDE     = 8'h7E;
  localparam logic [7:0] ASCII_CLS_DISP_CLR_CMD   = 8'h6A;
  localparam logic [7:0] ASCII_CLS_CURSOR_POS_CMD = 8'h48;

  localparam int unsigned c_cls_resp_max_param = 99;

  typedef logic [127:0] t_pmod_cls_ascii_line_16;

  typedef enum logic [1:0] {
    ST_TEXT,
    ST_ESC,
    ST_CSI,
    ST_PARAM
  } t_cls_resp_state;

  function automatic logic f_is_printable(input logic [7:0] ch);
    return (ch >= ASCII_CLS_CHAR_SPACE) && (ch <= ASCII_CLS_CHAR_TILDE);
  endfunction

  function automatic logic f_is_digit(input logic [7:0] ch);
    return (ch >= ASCII_CLS_CHAR_ZERO) && (ch <= ASCII_CLS_CHAR_NINE);
  endfunction

  // Decimal accumulate p*10 + digit, clamped so the 7-bit parameter never overflows.
  function automatic logic [6:0] f_param_accum(input logic [6:0] p, input logic [7:0] ch);
    logic [10:0] acc;
    acc = ({4'd0, p} * 11'd10) + {7'd0, ch[3:0]};
    if (acc > 11'(c_cls_resp_max_param)) return 7'(c_cls_resp_max_param);
    return acc[6:0];
  endfunction

endpackage

// File: rtl/spi_mode0_byte_rx.sv
// SPI mode 0 byte receiver: pin synchronizers, SCK/CSn edge detect and MSB-first shift register.
module spi_mode0_byte_rx (
  input  logic       i_ext_spi_clk_x,
  input  logic       i_arst_n,
  input  logic       i_sck,
  input  logic       i_csn,
  input  logic       i_copi,
  output logic       o_byte_stb,
  output logic [7:0] o_byte,
  output logic       o_csn_rise,
  output logic       o_partial
);

  logic [2:0] sck_sync_reg;
  logic [2:0] csn_sync_reg;
  logic [1:0] copi_sync_reg;
  logic [2:0] bit_cnt_reg;
  logic [6:0] shift_reg;
  logic [7:0] byte_reg;
  logic       byte_stb_reg;
  logic       csn_rise_reg;
  logic       partial_reg;

  logic sck_rise;
  logic csn_rise;
  logic cs_active;
  logic copi_bit;

  // Edges are taken between the second and third flop so the first two stages settle metastability.
  assign sck_rise  = sck_sync_reg[1] & ~sck_sync_reg[2];
  assign csn_rise  = csn_sync_reg[1] & ~csn_sync_reg[2];
  assign cs_active = ~csn_sync_reg[1];
  assign copi_bit  = copi_sync_reg[1];

  always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sck_sync_reg  <= 3'b000;
      csn_sync_reg  <= 3'b111;
      copi_sync_reg <= 2'b00;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[1:0], i_sck};
      csn_sync_reg  <= {csn_sync_reg[1:0], i_csn};
      copi_sync_reg <= {copi_sync_reg[0], i_copi};
    end
  end

  always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
    if (!i_arst_n) begin
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 7'd0;
      byte_reg     <= 8'd0;
      byte_stb_reg <= 1'b0;
      csn_rise_reg <= 1'b0;
      partial_reg  <= 1'b0;
    end else begin
      byte_stb_reg <= 1'b0;
      csn_rise_reg <= 1'b0;
      if (csn_rise) begin
        csn_rise_reg <= 1'b1;
        partial_reg  <= (bit_cnt_reg != 3'd0);
        bit_cnt_reg  <= 3'd0;
      end else if (cs_active && sck_rise) begin
        shift_reg   <= {shift_reg[5:0], copi_bit};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          byte_stb_reg <= 1'b1;
          byte_reg     <= {shift_reg, copi_bit};
        end
      end
    end
  end

  assign o_byte_stb = byte_stb_reg;
  assign o_byte     = byte_reg;
  assign o_csn_rise = csn_rise_reg;
  assign o_partial  = partial_reg;

endmodule

// File: rtl/pmod_cls_spi_responder.sv
// PMOD CLS display emulator: decodes text and ESC[ clear/cursor commands into a 2x16 buffer.
// Define PMOD_CLS_RESP_WRAP_EN to wrap the cursor to the other row after column 15.
module pmod_cls_spi_responder
  import pmod_stand_spi_solo_pkg::*;
#(
  parameter int unsigned FCLK = 20000000
) (
  input  logic                    i_ext_spi_clk_x,
  input  logic                    i_arst_n,
  input  logic                    i_sck,
  input  logic                    i_csn,
  input  logic                    i_copi,
  output t_pmod_cls_ascii_line_16 o_line1,
  output t_pmod_cls_ascii_line_16 o_line2,
  output logic                    o_cursor_row,
  output logic [3:0]              o_cursor_col,
  output logic                    o_byte_valid,
  output logic [7:0]              o_byte_data,
  output logic                    o_cmd_clear,
  output logic                    o_cmd_cursor,
  output logic                    o_frame_err,
  output logic                    o_seq_err
);

  if (FCLK == 0) begin : g_fclk_check
    $error("FCLK must be nonzero");
  end

  logic       rx_stb;
  logic [7:0] rx_byte;
  logic       rx_csn_rise;
  logic       rx_partial;

  spi_mode0_byte_rx u_byte_rx (
    .i_ext_spi_clk_x (i_ext_spi_clk_x),
    .i_arst_n        (i_arst_n),
    .i_sck           (i_sck),
    .i_csn           (i_csn),
    .i_copi          (i_copi),
    .o_byte_stb      (rx_stb),
    .o_byte          (rx_byte),
    .o_csn_rise      (rx_csn_rise),
    .o_partial       (rx_partial)
  );

  t_cls_resp_state         state_reg, state_next;
  logic [6:0]              p0_reg, p0_next;
  logic [6:0]              p1_reg, p1_next;
  logic                    idx_reg, idx_next;
  t_pmod_cls_ascii_line_16 line1_reg, line1_next;
  t_pmod_cls_ascii_line_16 line2_reg, line2_next;
  logic                    row_reg, row_next;
  logic [3:0]              col_reg, col_next;
  logic                    clr_reg, clr_next;
  logic                    cur_reg, cur_next;
  logic                    ferr_reg, ferr_next;
  logic                    serr_reg, serr_next;
  logic                    pend_reg, pend_next;
  logic                    pend_partial_reg, pend_partial_next;
  logic                    csn_partial;

  always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_reg        <= ST_TEXT;
      p0_reg           <= 7'd0;
      p1_reg           <= 7'd0;
      idx_reg          <= 1'b0;
      line1_reg        <= {16{ASCII_CLS_CHAR_SPACE}};
      line2_reg        <= {16{ASCII_CLS_CHAR_SPACE}};
      row_reg          <= 1'b0;
      col_reg          <= 4'd0;
      clr_reg          <= 1'b0;
      cur_reg          <= 1'b0;
      ferr_reg         <= 1'b0;
      serr_reg         <= 1'b0;
      pend_reg         <= 1'b0;
      pend_partial_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      p0_reg           <= p0_next;
      p1_reg           <= p1_next;
      idx_reg          <= idx_next;
      line1_reg        <= line1_next;
      line2_reg        <= line2_next;
      row_reg          <= row_next;
      col_reg          <= col_next;
      clr_reg          <= clr_next;
      cur_reg          <= cur_next;
      ferr_reg         <= ferr_next;
      serr_reg         <= serr_next;
      pend_reg         <= pend_next;
      pend_partial_reg <= pend_partial_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    p0_next           = p0_reg;
    p1_next           = p1_reg;
    idx_next          = idx_reg;
    line1_next        = line1_reg;
    line2_next        = line2_reg;
    row_next          = row_reg;
    col_next          = col_reg;
    clr_next          = 1'b0;
    cur_next          = 1'b0;
    ferr_next         = 1'b0;
    serr_next         = 1'b0;
    pend_next         = pend_reg;
    pend_partial_next = pend_partial_reg;
    csn_partial       = 1'b0;

    if (rx_stb) begin
      // A CSn rise landing with a byte is deferred so the byte is decoded first.
      if (rx_csn_rise) begin
        pend_next         = 1'b1;
        pend_partial_next = pend_partial_reg | rx_partial;
      end
      case (state_reg)
        ST_TEXT: begin
          if (rx_byte == ASCII_CLS_ESC) begin
            state_next = ST_ESC;
          end else if (f_is_printable(rx_byte)) begin
            if (row_reg) line2_next[{~col_reg, 3'b000} +: 8] = rx_byte;
            else         line1_next[{~col_reg, 3'b000} +: 8] = rx_byte;
            if (col_reg == 4'd15) begin
`ifdef PMOD_CLS_RESP_WRAP_EN
              col_next = 4'd0;
              row_next = ~row_reg;
`else
              col_next = col_reg;
`endif
            end else begin
              col_next = col_reg + 4'd1;
            end
          end
        end
        ST_ESC: begin
          if (rx_byte == ASCII_CLS_BRACKET) begin
            state_next = ST_CSI;
            p0_next    = 7'd0;
            p1_next    = 7'd0;
            idx_next   = 1'b0;
          end else begin
            serr_next  = 1'b1;
            state_next = ST_TEXT;
          end
        end
        ST_CSI, ST_PARAM: begin
          state_next = ST_TEXT;
          if (f_is_digit(rx_byte)) begin
            if (idx_reg) p1_next = f_param_accum(p1_reg, rx_byte);
            else         p0_next = f_param_accum(p0_reg, rx_byte);
            state_next = ST_PARAM;
          end else if (rx_byte == ASCII_CLS_CHAR_SEMICOLON) begin
            if (idx_reg) begin
              serr_next = 1'b1;
            end else begin
              idx_next   = 1'b1;
              state_next = ST_PARAM;
            end
          end else if (rx_byte == ASCII_CLS_DISP_CLR_CMD) begin
            if (p0_reg == 7'd0) begin
              line1_next = {16{ASCII_CLS_CHAR_SPACE}};
              line2_next = {16{ASCII_CLS_CHAR_SPACE}};
              row_next   = 1'b0;
              col_next   = 4'd0;
              clr_next   = 1'b1;
            end
          end else if (rx_byte == ASCII_CLS_CURSOR_POS_CMD) begin
            if ((p0_reg <= 7'd1) && (p1_reg <= 7'd15)) begin
              row_next = p0_reg[0];
              col_next = p1_reg[3:0];
              cur_next = 1'b1;
            end
          end else begin
            serr_next = 1'b1;
          end
        end
        default: state_next = ST_TEXT;
      endcase
    end else if (rx_csn_rise || pend_reg) begin
      csn_partial       = (rx_csn_rise & rx_partial) | (pend_reg & pend_partial_reg);
      ferr_next         = csn_partial || (state_reg != ST_TEXT);
      state_next        = ST_TEXT;
      pend_next         = 1'b0;
      pend_partial_next = 1'b0;
    end
  end

  assign o_line1      = line1_reg;
  assign o_line2      = line2_reg;
  assign o_cursor_row = row_reg;
  assign o_cursor_col = col_reg;
  assign o_byte_valid = rx_stb;
  assign o_byte_data  = rx_byte;
  assign o_cmd_clear  = clr_reg;
  assign o_cmd_cursor = cur_reg;
  assign o_frame_err  = ferr_reg;
  assign o_seq_err    = serr_reg;

endmodule

// File: tb/tb_pmod_cls_spi_responder.sv
// Directed bench for the PMOD CLS responder: drives SPI frames and checks buffer, cursor and pulses.
module tb_pmod_cls_spi_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sck = 1'b0;
  logic         csn = 1'b1;
  logic         copi = 1'b0;
  logic [127:0] line1, line2;
  logic         row;
  logic [3:0]   col;
  logic         bv;
  logic [7:0]   bdata;
  logic         clr, cur, ferr, serr;

  int total = 0;
  int bad = 0;
  int n_bv = 0, n_clr = 0, n_cur = 0, n_ferr = 0, n_serr = 0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  pmod_cls_spi_responder #(.FCLK(20000000)) dut (
    .i_ext_spi_clk_x (clk),
    .i_arst_n        (rst_n),
    .i_sck           (sck),
    .i_csn           (csn),
    .i_copi          (copi),
    .o_line1         (line1),
    .o_line2         (line2),
    .o_cursor_row    (row),
    .o_cursor_col    (col),
    .o_byte_valid    (bv),
    .o_byte_data     (bdata),
    .o_cmd_clear     (clr),
    .o_cmd_cursor    (cur),
    .o_frame_err     (ferr),
    .o_seq_err       (serr)
  );

  always @(negedge clk) begin
    if (bv)   n_bv   <= n_bv + 1;
    if (clr)  n_clr  <= n_clr + 1;
    if (cur)  n_cur  <= n_cur + 1;
    if (ferr) n_ferr <= n_ferr + 1;
    if (serr) n_serr <= n_serr + 1;
  end

  function automatic logic [127:0] fill(input logic [7:0] c);
    return {16{c}};
  endfunction

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk); copi = b[i];
      repeat (5) @(negedge clk); sck = 1'b1;
      repeat (5) @(negedge clk); sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    @(negedge clk); csn = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (5) @(negedge clk); csn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) txq.push_back(s[i]);
  endtask

  task automatic push_esc(input string s);
    txq.push_back(8'h1B);
    push_str(s);
  endtask

  task automatic send_frame();
    logic [7:0] b;
    frame_begin();
    while (txq.size() > 0) begin
      b = txq.pop_front();
      spi_bits(b, 8);
    end
    frame_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (line1 !== fill(8'h20)) begin bad++; $display("FAIL reset_line1: got %h want %h", line1, fill(8'h20)); end
    total++; if (line2 !== fill(8'h20)) begin bad++; $display("FAIL reset_line2: got %h want %h", line2, fill(8'h20)); end
    total++; if ({row, col} !== 5'd0) begin bad++; $display("FAIL reset_cursor: got %0d,%0d want 0,0", row, col); end
    total++; if (bdata !== 8'h00) begin bad++; $display("FAIL reset_byte_data: got %h want 00", bdata); end
    total++; if ({bv, clr, cur, ferr, serr} !== 5'b0) begin bad++; $display("FAIL reset_pulses: got %b want 00000", {bv, clr, cur, ferr, serr}); end
  endtask

  task automatic test_clear();
    int c0;
    push_esc("[0;0H"); push_str("AAAAAAAAAAAAAAAA");
    push_esc("[1;0H"); push_str("AAAAAAAAAAAAAAAA");
    send_frame();
    total++; if (line1 !== fill(8'h41)) begin bad++; $display("FAIL fill_line1: got %h want %h", line1, fill(8'h41)); end
    total++; if (line2 !== fill(8'h41)) begin bad++; $display("FAIL fill_line2: got %h want %h", line2, fill(8'h41)); end
    c0 = n_clr;
    push_esc("[0j");
    send_frame();
    total++; if (line1 !== fill(8'h20)) begin bad++; $display("FAIL clear_line1: got %h want %h", line1, fill(8'h20)); end
    total++; if (line2 !== fill(8'h20)) begin bad++; $display("FAIL clear_line2: got %h want %h", line2, fill(8'h20)); end
    total++; if ({row, col} !== 5'd0) begin bad++; $display("FAIL clear_cursor: got %0d,%0d want 0,0", row, col); end
    total++; if (n_clr - c0 != 1) begin bad++; $display("FAIL clear_pulse: got %0d want 1", n_clr - c0); end
    total++; if (bdata !== 8'h6A) begin bad++; $display("FAIL clear_byte_data: got %h want 6a", bdata); end
  endtask

  task automatic test_cursor_text();
    int c0, b0;
    logic [127:0] exp2;
    logic [4:0]   exp_cur;
    exp2 = "HELLO WORLD 1234";
`ifdef PMOD_CLS_RESP_WRAP_EN
    exp_cur = 5'd0;
`else
    exp_cur = {1'b1, 4'd15};
`endif
    c0 = n_cur;
    push_esc("[1;00H");
    send_frame();
    total++; if ({row, col} !== {1'b1, 4'd0}) begin bad++; $display("FAIL cursor_pos: got %0d,%0d want 1,0", row, col); end
    total++; if (n_cur - c0 != 1) begin bad++; $display("FAIL cursor_pulse: got %0d want 1", n_cur - c0); end
    b0 = n_bv;
    push_str("HELLO WORLD 1234");
    send_frame();
    total++; if (line2 !== exp2) begin bad++; $display("FAIL text_line2: got %h want %h", line2, exp2); end
    total++; if (line1 !== fill(8'h20)) begin bad++; $display("FAIL text_line1: got %h want %h", line1, fill(8'h20)); end
    total++; if ({row, col} !== exp_cur) begin bad++; $display("FAIL text_cursor: got %0d,%0d want %0d,%0d", row, col, exp_cur[4], exp_cur[3:0]); end
    total++; if (n_bv - b0 != 16) begin bad++; $display("FAIL text_byte_count: got %0d want 16", n_bv - b0); end
    total++; if (bdata !== 8'h34) begin bad++; $display("FAIL text_byte_data: got %h want 34", bdata); end
  endtask

  task automatic test_frame_err();
    int f0, b0;
    logic [4:0] cur0;
    cur0 = {row, col};
    f0 = n_ferr; b0 = n_bv;
    frame_begin();
    spi_bits(8'hA5, 5);
    frame_end();
    total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL partial_frame_err: got %0d want 1", n_ferr - f0); end
    total++; if (n_bv - b0 != 0) begin bad++; $display("FAIL partial_no_byte: got %0d want 0", n_bv - b0); end
    total++; if (line2 !== 128'("HELLO WORLD 1234")) begin bad++; $display("FAIL partial_line2: got %h want unchanged", line2); end
    total++; if ({row, col} !== cur0) begin bad++; $display("FAIL partial_cursor: got %0d,%0d want %0d,%0d", row, col, cur0[4], cur0[3:0]); end
  endtask

  task automatic test_bad_cursor();
    int c0, s0, f0;
    logic [4:0] cur0;
    cur0 = {row, col};
    c0 = n_cur; s0 = n_serr; f0 = n_ferr;
    push_esc("[2;0H");
    send_frame();
    total++; if ({row, col} !== cur0) begin bad++; $display("FAIL badrow_cursor: got %0d,%0d want %0d,%0d", row, col, cur0[4], cur0[3:0]); end
    total++; if (n_cur - c0 != 0) begin bad++; $display("FAIL badrow_no_pulse: got %0d want 0", n_cur - c0); end
    total++; if (n_serr - s0 + n_ferr - f0 != 0) begin bad++; $display("FAIL badrow_no_err: got %0d want 0", n_serr - s0 + n_ferr - f0); end
    push_esc("A");
    send_frame();
    total++; if (n_serr - s0 != 1) begin bad++; $display("FAIL esc_seq_err: got %0d want 1", n_serr - s0); end
    total++; if (line1 !== fill(8'h20)) begin bad++; $display("FAIL esc_no_write: got %h want %h", line1, fill(8'h20)); end
  endtask

  task automatic test_wrap();
    logic [127:0] exp1, exp2;
    logic [4:0]   exp_cur;
    int c0;
`ifdef PMOD_CLS_RESP_WRAP_EN
    exp1 = "ABCDEFGHIJKLMNOP";
    exp2 = {8'h51, {15{8'h20}}};
    exp_cur = {1'b1, 4'd1};
`else
    exp1 = "ABCDEFGHIJKLMNOQ";
    exp2 = fill(8'h20);
    exp_cur = {1'b0, 4'd15};
`endif
    c0 = n_clr;
    push_esc("[j");
    push_str("ABCDEFGHIJKLMNOPQ");
    send_frame();
    total++; if (n_clr - c0 != 1) begin bad++; $display("FAIL wrap_clear_pulse: got %0d want 1", n_clr - c0); end
    total++; if (line1 !== exp1) begin bad++; $display("FAIL wrap_line1: got %h want %h", line1, exp1); end
    total++; if (line2 !== exp2) begin bad++; $display("FAIL wrap_line2: got %h want %h", line2, exp2); end
    total++; if ({row, col} !== exp_cur) begin bad++; $display("FAIL wrap_cursor: got %0d,%0d want %0d,%0d", row, col, exp_cur[4], exp_cur[3:0]); end
  endtask

  task automatic test_escape_abort();
    int f0, s0;
    logic [127:0] exp2;
    exp2 = line2;
    exp2[(15 - 5) * 8 +: 8] = 8'h5A;
    push_esc("[1;5H");
    send_frame();
    f0 = n_ferr; s0 = n_serr;
    push_esc("[1");
    send_frame();
    total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL abort_frame_err: got %0d want 1", n_ferr - f0); end
    push_str("Z");
    send_frame();
    total++; if (line2 !== exp2) begin bad++; $display("FAIL abort_text_line2: got %h want %h", line2, exp2); end
    total++; if ({row, col} !== {1'b1, 4'd6}) begin bad++; $display("FAIL abort_cursor: got %0d,%0d want 1,6", row, col); end
    total++; if (n_serr - s0 != 0) begin bad++; $display("FAIL abort_no_seq_err: got %0d want 0", n_serr - s0); end
  endtask

  task automatic test_params();
    int c0, s0;
    c0 = n_cur; s0 = n_serr;
    push_esc("[999;5H");
    push_esc("[0;16H");
    send_frame();
    total++; if ({row, col} !== {1'b1, 4'd6}) begin bad++; $display("FAIL sat_cursor: got %0d,%0d want 1,6", row, col); end
    total++; if (n_cur - c0 != 0) begin bad++; $display("FAIL sat_no_pulse: got %0d want 0", n_cur - c0); end
    push_esc("[1;15H");
    send_frame();
    total++; if ({row, col} !== {1'b1, 4'd15}) begin bad++; $display("FAIL edge_cursor: got %0d,%0d want 1,15", row, col); end
    total++; if (n_cur - c0 != 1) begin bad++; $display("FAIL edge_pulse: got %0d want 1", n_cur - c0); end
    push_esc("[1;;");
    send_frame();
    total++; if (n_serr - s0 != 1) begin bad++; $display("FAIL double_semi: got %0d want 1", n_serr - s0); end
  endtask

  task automatic test_latency();
    frame_begin();
    spi_bits(8'h7F, 7);
    @(negedge clk); copi = 1'b1;
    repeat (5) @(negedge clk); sck = 1'b1;
    @(posedge clk); #1;
    total++; if (bv !== 1'b0) begin bad++; $display("FAIL latency_clk1: got %b want 0", bv); end
    @(posedge clk); #1;
    total++; if (bv !== 1'b0) begin bad++; $display("FAIL latency_clk2: got %b want 0", bv); end
    @(posedge clk); #1;
    total++; if (bv !== 1'b1) begin bad++; $display("FAIL latency_clk3: got %b want 1", bv); end
    total++; if (bdata !== 8'h7F) begin bad++; $display("FAIL latency_data: got %h want 7f", bdata); end
    @(posedge clk); #1;
    total++; if (bv !== 1'b0) begin bad++; $display("FAIL latency_one_cycle: got %b want 0", bv); end
    repeat (3) @(negedge clk); sck = 1'b0;
    frame_end();
  endtask

  task automatic test_async_reset();
    logic [127:0] exp1;
    frame_begin();
    spi_bits(8'h55, 4);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++; if (line1 !== fill(8'h20)) begin bad++; $display("FAIL arst_line1: got %h want %h", line1, fill(8'h20)); end
    total++; if (line2 !== fill(8'h20)) begin bad++; $display("FAIL arst_line2: got %h want %h", line2, fill(8'h20)); end
    total++; if ({row, col} !== 5'd0) begin bad++; $display("FAIL arst_cursor: got %0d,%0d want 0,0", row, col); end
    total++; if (bdata !== 8'h00) begin bad++; $display("FAIL arst_byte_data: got %h want 00", bdata); end
    csn = 1'b1; sck = 1'b0; copi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp1 = fill(8'h20);
    exp1[127:120] = 8'h4B;
    push_str("K");
    send_frame();
    total++; if (line1 !== exp1) begin bad++; $display("FAIL arst_recover: got %h want %h", line1, exp1); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_cursor_text();
    test_frame_err();
    test_bad_cursor();
    test_wrap();
    test_escape_abort();
    test_params();
    test_latency();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
